// File: rtl/regfile_writeback_if.sv
// Bus bundle for the register-file write-back sequencer: ALU/LSU result inputs,
// write-port outputs and the pending-write scoreboard. WB_BYPASS_EN adds the fwd_* early-forward signals.
interface regfile_writeback_if #(
    parameter int unsigned XLEN = 64
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     pending_mask;
`ifdef WB_BYPASS_EN
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready, wb_we, wb_rd, wb_data, pending_mask
`ifdef WB_BYPASS_EN
        , input fwd_valid, fwd_rd, fwd_data
`endif
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output lsu_ready, wb_we, wb_rd, wb_data, pending_mask
`ifdef WB_BYPASS_EN
        , output fwd_valid, fwd_rd, fwd_data
`endif
    );
endinterface

// File: rtl/regfile_writeback.sv
// Merges ALU results (priority, never stalled) and FIFO-buffered LSU results onto the
// single register-file write port, with a pending-write scoreboard. Optional: WB_BYPASS_EN.
module regfile_writeback #(
    parameter int unsigned LSU_FIFO_DEPTH = 2,
    parameter int unsigned XLEN           = 64
) (
    input logic                 clk,
    input logic                 rst,
    regfile_writeback_if.slave  bus
);
    localparam int unsigned PW = $clog2(LSU_FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(LSU_FIFO_DEPTH);

    logic            live_q [LSU_FIFO_DEPTH];
    logic            live_d [LSU_FIFO_DEPTH];
    logic [4:0]      rd_q   [LSU_FIFO_DEPTH];
    logic [4:0]      rd_d   [LSU_FIFO_DEPTH];
    logic [XLEN-1:0] data_q [LSU_FIFO_DEPTH];
    logic [XLEN-1:0] data_d [LSU_FIFO_DEPTH];

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            lsu_ready_q, lsu_ready_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [31:0]     pending_mask_q, pending_mask_d;

    logic            push;
    logic            pop;
    logic            sel_valid;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    // Write-port arbitration: ALU first, otherwise drain the FIFO head.
    always_comb begin
        push      = bus.lsu_valid && lsu_ready_q;
        pop       = !bus.alu_valid && (count_q != '0);
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (bus.alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = bus.alu_rd;
            sel_data  = bus.alu_data;
        end else if (pop && live_q[rd_ptr_q]) begin
            sel_valid = 1'b1;
            sel_rd    = rd_q[rd_ptr_q];
            sel_data  = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        live_d         = live_q;
        rd_d           = rd_q;
        data_d         = data_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        wb_we_d        = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        pending_mask_d = '0;

        // The ALU result is younger than anything already queued for the same rd.
        for (int i = 0; i < int'(LSU_FIFO_DEPTH); i++) begin
            if (bus.alu_valid && live_q[i] && (rd_q[i] == bus.alu_rd)) begin
                live_d[i] = 1'b0;
            end
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PW'(1);
        end

        // Pushed after the kill so a same-cycle LSU result survives.
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
            rd_d[wr_ptr_q]   = bus.lsu_rd;
            data_d[wr_ptr_q] = bus.lsu_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        count_d     = count_q + CW'(push) - CW'(pop);
        lsu_ready_d = (count_d != FULL_CNT);

        if (sel_valid) begin
            wb_we_d   = (sel_rd != 5'd0);
            wb_rd_d   = sel_rd;
            wb_data_d = sel_data;
        end

        for (int i = 0; i < int'(LSU_FIFO_DEPTH); i++) begin
            if (live_d[i]) begin
                pending_mask_d[rd_d[i]] = 1'b1;
            end
        end
        pending_mask_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LSU_FIFO_DEPTH); i++) begin
                live_q[i] <= 1'b0;
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            lsu_ready_q    <= 1'b0;
            wb_we_q        <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            pending_mask_q <= '0;
        end else begin
            live_q         <= live_d;
            rd_q           <= rd_d;
            data_q         <= data_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            lsu_ready_q    <= lsu_ready_d;
            wb_we_q        <= wb_we_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            pending_mask_q <= pending_mask_d;
        end
    end

    assign bus.lsu_ready    = lsu_ready_q;
    assign bus.wb_we        = wb_we_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.pending_mask = pending_mask_q;

`ifdef WB_BYPASS_EN
    // Early view of next cycle's write for read-stage forwarding.
    assign bus.fwd_valid = sel_valid && (sel_rd != 5'd0);
    assign bus.fwd_rd    = sel_rd;
    assign bus.fwd_data  = sel_data;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_regfile_writeback;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic            live;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_writeback_if #(.XLEN(XLEN)) bus();

    regfile_writeback #(.LSU_FIFO_DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    ent_t            mq[$];
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    logic [31:0]     m_mask;
    logic            m_ready;

    logic            ms_v;
    logic [4:0]      ms_r;
    logic [XLEN-1:0] ms_d;
    logic            m_push;
    ent_t            m_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // What the write port should take this cycle, from the current inputs and queue.
    function automatic void msel(output logic v, output logic [4:0] r, output logic [XLEN-1:0] d);
        v = 1'b0; r = '0; d = '0;
        if (bus.alu_valid) begin
            v = 1'b1; r = bus.alu_rd; d = bus.alu_data;
        end else if (mq.size() != 0 && mq[0].live) begin
            v = 1'b1; r = mq[0].rd; d = mq[0].data;
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_we = 1'b0; m_rd = '0; m_data = '0; m_mask = '0; m_ready = 1'b0;
        end else begin
            m_push = bus.lsu_valid && m_ready;
            msel(ms_v, ms_r, ms_d);
            if (bus.alu_valid) begin
                foreach (mq[i]) if (mq[i].rd == bus.alu_rd) mq[i].live = 1'b0;
            end else if (mq.size() != 0) begin
                void'(mq.pop_front());
            end
            if (m_push) begin
                m_e.live = 1'b1; m_e.rd = bus.lsu_rd; m_e.data = bus.lsu_data;
                mq.push_back(m_e);
            end
            if (ms_v) begin
                m_we = (ms_r != 5'd0); m_rd = ms_r; m_data = ms_d;
            end else begin
                m_we = 1'b0;
            end
            m_mask = '0;
            foreach (mq[i]) if (mq[i].live && mq[i].rd != 5'd0) m_mask[mq[i].rd] = 1'b1;
            m_ready = (mq.size() < DEPTH);
        end
    end

`ifdef WB_BYPASS_EN
    logic            c_v;
    logic [4:0]      c_r;
    logic [XLEN-1:0] c_d;
    logic            prev_fv = 1'b0;
    logic [4:0]      prev_fr = '0;
`endif

    always @(negedge clk) begin
        if (chk_en) begin
            check("wb_we", 64'(bus.wb_we), 64'(m_we));
            check("wb_rd", 64'(bus.wb_rd), 64'(m_rd));
            check("wb_data", 64'(bus.wb_data), 64'(m_data));
            check("pending_mask", 64'(bus.pending_mask), 64'(m_mask));
            check("lsu_ready", 64'(bus.lsu_ready), 64'(m_ready));
`ifdef WB_BYPASS_EN
            if (prev_fv) check("fwd_lead", 64'(bus.wb_rd), 64'(prev_fr));
            if (!rst) begin
                msel(c_v, c_r, c_d);
                check("fwd_valid", 64'(bus.fwd_valid), 64'(c_v && c_r != 5'd0));
                if (c_v) begin
                    check("fwd_rd", 64'(bus.fwd_rd), 64'(c_r));
                    check("fwd_data", 64'(bus.fwd_data), 64'(c_d));
                end
                prev_fv = bus.fwd_valid;
                prev_fr = bus.fwd_rd;
            end else begin
                prev_fv = 1'b0;
            end
`endif
        end
    end

    task automatic drive(input logic av, input logic [4:0] ar, input logic [63:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [63:0] ld);
        bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
        bus.lsu_valid = lv; bus.lsu_rd = lr; bus.lsu_data = ld;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_en = 1'b1;
            check("rst_wb_we", 64'(bus.wb_we), 64'd0);
            check("rst_mask", 64'(bus.pending_mask), 64'd0);
            check("rst_ready", 64'(bus.lsu_ready), 64'd0);
        end
        rst = 1'b0;
        idle();
        cyc();
        check("ready_after_rst", 64'(bus.lsu_ready), 64'd1);

        // ALU write
        drive(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 64'd0);
        cyc();
        check("alu_we", 64'(bus.wb_we), 64'd1);
        check("alu_rd", 64'(bus.wb_rd), 64'd5);
        check("alu_data", 64'(bus.wb_data), 64'hDEADBEEF00000001);

        // Contention and back-pressure
        drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd7, 64'h70); cyc();
        drive(1'b1, 5'd2, 64'h2, 1'b1, 5'd8, 64'h80); cyc();
        check("cont_mask", 64'(bus.pending_mask), 64'h180);
        check("cont_ready", 64'(bus.lsu_ready), 64'd0);
        drive(1'b1, 5'd3, 64'h3, 1'b0, 5'd0, 64'd0); cyc();
        drive(1'b1, 5'd4, 64'h4, 1'b0, 5'd0, 64'd0); cyc();
        check("cont_ready_hold", 64'(bus.lsu_ready), 64'd0);
        idle(); cyc();
        check("drain1_we", 64'(bus.wb_we), 64'd1);
        check("drain1_rd", 64'(bus.wb_rd), 64'd7);
        check("drain1_data", 64'(bus.wb_data), 64'h70);
        cyc();
        check("drain2_rd", 64'(bus.wb_rd), 64'd8);
        check("drain2_data", 64'(bus.wb_data), 64'h80);
        check("drain_mask", 64'(bus.pending_mask), 64'd0);

        // Kill
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h11); cyc();
        check("kill_mask_set", 64'(bus.pending_mask), 64'h200);
        drive(1'b1, 5'd9, 64'h22, 1'b0, 5'd0, 64'd0); cyc();
        check("kill_we", 64'(bus.wb_we), 64'd1);
        check("kill_data", 64'(bus.wb_data), 64'h22);
        check("kill_mask_clr", 64'(bus.pending_mask), 64'd0);
        idle(); cyc();
        check("killed_no_we", 64'(bus.wb_we), 64'd0);
        check("killed_hold_data", 64'(bus.wb_data), 64'h22);

        // x0
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF); cyc();
        check("x0_mask", 64'(bus.pending_mask), 64'd0);
        idle(); cyc();
        check("x0_we", 64'(bus.wb_we), 64'd0);
        check("x0_rd", 64'(bus.wb_rd), 64'd0);
        check("x0_data", 64'(bus.wb_data), 64'hFF);
        check("x0_ready", 64'(bus.lsu_ready), 64'd1);

        // Wrap: back-to-back pushes, each drained the following cycle
        for (int i = 1; i <= 10; i++) begin
            drive(1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 64'(32'h100 + i));
            cyc();
            if (i >= 2) begin
                check("wrap_we", 64'(bus.wb_we), 64'd1);
                check("wrap_rd", 64'(bus.wb_rd), 64'(i - 1));
                check("wrap_data", 64'(bus.wb_data), 64'(32'h100 + i - 1));
            end
        end
        idle(); cyc();
        check("wrap_last_rd", 64'(bus.wb_rd), 64'd10);
        check("wrap_last_data", 64'(bus.wb_data), 64'h10A);

        // Randomized traffic with rare resets
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(99) == 0);
            drive($urandom_range(9) < 3,
                  ($urandom_range(9) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7)),
                  {$urandom, $urandom},
                  $urandom_range(9) < 6,
                  ($urandom_range(9) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7)),
                  {$urandom, $urandom});
            cyc();
        end
        rst = 1'b0;
        idle();
        repeat (5) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side sequencer for the 32 x 64-bit integer register file. It merges results from the ALU and the load/store unit into the register file's single write port (rd, write_data, we).
- ALU results have fixed priority and are never stalled.
- LSU results are buffered in a small FIFO and drained on idle cycles.
- Exports a pending-write scoreboard so decode can stall on registers with queued writes.

Parameters:
- LSU_FIFO_DEPTH, 2, number of buffered LSU results (power of two, >= 2).
- XLEN, 64, data width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  5  ALU destination register
- alu_data  input  XLEN  ALU result
- lsu_valid  input  1  LSU result offered
- lsu_ready  output  1  FIFO can accept an LSU result
- lsu_rd  input  5  LSU destination register
- lsu_data  input  XLEN  LSU load data
- wb_we  output  1  register file write enable
- wb_rd  output  5  register file write index
- wb_data  output  XLEN  register file write data
- pending_mask  output  32  bit n set = a live queued write to xn

Behaviour:
- Reset, clk and rst are fixed: one clock `clk`; reset `rst` is synchronous and active-high. While rst is high:
  - wb_we=0, wb_rd=0, wb_data=0;
  - FIFO empty with all entries invalid;
  - pending_mask=0; lsu_ready=0.
  - lsu_ready goes to 1 on the first cycle after rst deasserts.
  - Reset asserted mid-operation discards all queued entries; no write issues for them.
- LSU handshake:
  - Transfer occurs when lsu_valid && lsu_ready.
  - lsu_ready = !full, computed from the registered occupancy only. A full FIFO refuses a push even in a cycle where it also pops.
  - Each entry holds {live, rd, data}.
- Write selection, evaluated each cycle:
  - If alu_valid: the ALU result is selected.
  - Else, if the FIFO is non-empty: the head entry is popped. It is selected only if live; otherwise it is discarded silently.
  - Else: nothing is selected.
- Output timing: wb_we/wb_rd/wb_data are registered, so there is 1 cycle of latency from the selection cycle.
  - wb_we=1 only for a selected write with rd != 0.
  - Writes to x0 are consumed (popped or accepted) with wb_we=0. wb_rd and wb_data still update.
  - When wb_we=0, wb_rd and wb_data hold their previous values, except in the x0 case above.
- Ordering:
  - An ALU write to rd kills, in the same cycle, every live queued entry with the same rd, because the ALU result is architecturally younger.
  - A push in the same cycle as a matching ALU write is not killed (the LSU result is younger).
  - FIFO order is strictly preserved otherwise.
- Scoreboard: pending_mask is registered.
  - Bit n = OR over live queued entries with rd==n, n!=0.
  - Bit 0 is always 0.
  - pending_mask reflects state after the cycle's push, pop and kill.
- Pointers:
  - Read and write pointers wrap modulo LSU_FIFO_DEPTH.
  - Occupancy counter width is clog2(LSU_FIFO_DEPTH)+1.
  - Full means count == LSU_FIFO_DEPTH; empty means count == 0.
  - A simultaneous push and pop leaves count unchanged.
- Data passes through unmodified; no width conversion.

Optional Feature:
- WB_BYPASS_EN defined: adds outputs fwd_valid (1), fwd_rd (5), fwd_data (XLEN).
  - These are the combinational selection of the current cycle, i.e. the value wb_* will carry next cycle.
  - fwd_valid=0 for x0 or when nothing is selected.
  - The read stage can forward one cycle early.
- Not defined: these ports are absent; there is no combinational path from inputs to outputs.

Test Plan:
- Reset:
  - Stimulus: hold rst 3 cycles with alu_valid=1, lsu_valid=1.
  - Required: wb_we=0, pending_mask=0 and lsu_ready=0 throughout; lsu_ready=1 on the cycle after release.
- ALU write:
  - Stimulus: alu_valid=1, alu_rd=5, alu_data=0xDEAD_BEEF_0000_0001.
  - Required: next cycle wb_we=1, wb_rd=5, wb_data=0xDEADBEEF00000001.
- Contention and back-pressure:
  - Stimulus: ALU busy 4 cycles (rd=1..4); LSU pushes rd=7 then rd=8.
  - Required:
    - pending_mask=0x180 and lsu_ready=0 after the second push;
    - after the ALU goes idle, wb writes x7 then x8 on consecutive cycles;
    - pending_mask returns to 0.
- Kill:
  - Stimulus: queue LSU rd=9 with data=0x11; then an ALU write to rd=9 with data=0x22.
  - Required: x9 is written once with 0x22; the queued entry is dropped with no write; pending_mask bit 9 clears.
- x0:
  - Stimulus: LSU push with rd=0, data=0xFF.
  - Required: entry consumed, wb_we stays 0, pending_mask stays 0, lsu_ready recovers.
- Wrap and bypass:
  - Stimulus: 10 back-to-back LSU pushes with rd=1..10 and no ALU traffic.
  - Required:
    - all 10 writes appear in order;
    - wrap-around works across several pointer cycles;
    - with WB_BYPASS_EN, fwd_rd leads wb_rd by exactly 1 cycle.
